// File: rtl/pipeline_id_stage_hs_if.sv
// ID-stage handshake bundle: IF/ID side, hazard/forwarding inputs, and the ID/EX register outputs.
// slave is the ID stage view; master is the surrounding pipeline (or bench) view.
interface pipeline_id_stage_hs_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruction_ID;
    logic [XLEN-1:0]  pc_ID;
    logic [XLEN-1:0]  data_reg_read_1;
    logic [XLEN-1:0]  data_reg_read_2;
    logic [4:0]       addr_reg_read_1;
    logic [4:0]       addr_reg_read_2;
    logic             flush;
    logic [4:0]       ex_rd, mem_rd, wb_rd;
    logic             ex_wr_en, mem_wr_en, wb_wr_en;
    logic             ex_is_load;
    logic [XLEN-1:0]  ex_fwd_data, mem_fwd_data, wb_fwd_data;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  reg_data1_ID, reg_data2_ID;
    logic [4:0]       rs1_ID, rs2_ID, rd_ID;
    logic [6:0]       opcode_ID;
    logic [2:0]       funct3_ID;
    logic [6:0]       funct7_ID;
    logic [XLEN-1:0]  imm_ID;
    logic [XLEN-1:0]  pc_out;
    logic             rf_wr_en, do_jump, alu_a_sel, alu_b_sel;
    logic [3:0]       alu_ctrl;
    logic [2:0]       BrType;
    logic [1:0]       rf_wr_sel;
    logic [2:0]       dm_rd_ctrl, dm_wr_ctrl;
    logic [CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, instruction_ID, pc_ID, data_reg_read_1, data_reg_read_2, flush,
               ex_rd, mem_rd, wb_rd, ex_wr_en, mem_wr_en, wb_wr_en, ex_is_load,
               ex_fwd_data, mem_fwd_data, wb_fwd_data, out_ready,
        output in_ready, addr_reg_read_1, addr_reg_read_2, out_valid,
               reg_data1_ID, reg_data2_ID, rs1_ID, rs2_ID, rd_ID, opcode_ID, funct3_ID,
               funct7_ID, imm_ID, pc_out, rf_wr_en, do_jump, alu_a_sel, alu_b_sel,
               alu_ctrl, BrType, rf_wr_sel, dm_rd_ctrl, dm_wr_ctrl, stall_cnt
    );

    modport master (
        output in_valid, instruction_ID, pc_ID, data_reg_read_1, data_reg_read_2, flush,
               ex_rd, mem_rd, wb_rd, ex_wr_en, mem_wr_en, wb_wr_en, ex_is_load,
               ex_fwd_data, mem_fwd_data, wb_fwd_data, out_ready,
        input  in_ready, addr_reg_read_1, addr_reg_read_2, out_valid,
               reg_data1_ID, reg_data2_ID, rs1_ID, rs2_ID, rd_ID, opcode_ID, funct3_ID,
               funct7_ID, imm_ID, pc_out, rf_wr_en, do_jump, alu_a_sel, alu_b_sel,
               alu_ctrl, BrType, rf_wr_sel, dm_rd_ctrl, dm_wr_ctrl, stall_cnt
    );
endinterface

// File: rtl/pipeline_id_stage_hs.sv
// ID stage with ID/EX register, valid/ready handshake, load-use bubbles, EX/MEM/WB
// operand forwarding, flush on redirect and a saturating load-use stall counter.

// One forwarding mux per source operand; EX > MEM > WB > register file, x0 reads 0.
module pipeline_id_stage_hs_fwd #(
    parameter int XLEN = 64
) (
    input  logic [4:0]      r,
    input  logic [XLEN-1:0] rf_data,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      mem_rd,
    input  logic [4:0]      wb_rd,
    input  logic            ex_wr_en,
    input  logic            mem_wr_en,
    input  logic            wb_wr_en,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_data,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] op
);
    always_comb begin
        op = rf_data;
        if (r == 5'd0)                                  op = '0;
        else if (ex_wr_en && !ex_is_load && ex_rd == r) op = ex_data;
        else if (mem_wr_en && mem_rd == r)              op = mem_data;
        else if (wb_wr_en && wb_rd == r)                op = wb_data;
    end
endmodule

module pipeline_id_stage_hs #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   reset,
    pipeline_id_stage_hs_if.slave bus
);
    localparam int NUM_OPS = 2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_RW    = 7'b0111011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_IW    = 7'b0011011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

    // rf_wr_sel: 1 = ALU result, 2 = load data, 3 = pc+4
    typedef struct packed {
        logic       rf_wr_en;
        logic       do_jump;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [3:0] alu_ctrl;
        logic [2:0] br_type;
        logic [1:0] rf_wr_sel;
        logic [2:0] dm_rd;
        logic [2:0] dm_wr;
    } ctrl_t;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    endfunction

    logic [31:0] inst;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        uses_rs1, uses_rs2, hazard, advance;
    logic [63:0] imm64;
    ctrl_t       ctrl_d;

    assign inst = bus.instruction_ID;
    assign opc  = inst[6:0];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];
    assign f3   = inst[14:12];
    assign f7   = inst[31:25];

    assign bus.addr_reg_read_1 = rs1;
    assign bus.addr_reg_read_2 = rs2;

    assign uses_rs1 = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign uses_rs2 = (opc == OP_R || opc == OP_RW || opc == OP_ST || opc == OP_BR);

    assign hazard = bus.in_valid && bus.ex_is_load && bus.ex_wr_en && (bus.ex_rd != 5'd0) &&
                    ((uses_rs1 && bus.ex_rd == rs1) || (uses_rs2 && bus.ex_rd == rs2));

    logic out_valid_q;
    assign advance      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = bus.flush || (advance && !hazard);

    // Immediate decoder, built at 64 bits then truncated to XLEN.
    always_comb begin
        imm64 = '0;
        case (opc)
            OP_I, OP_IW, OP_LD, OP_JALR: imm64 = {{52{inst[31]}}, inst[31:20]};
            OP_ST:           imm64 = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            OP_BR:           imm64 = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm64 = {{32{inst[31]}}, inst[31:12], 12'b0};
            OP_JAL:          imm64 = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:         imm64 = '0;
        endcase
    end

    always_comb begin
        ctrl_d = '0;
        case (opc)
            OP_R, OP_RW: begin
                ctrl_d.rf_wr_en  = 1'b1;
                ctrl_d.alu_ctrl  = alu_op(f3, f7[5]);
                ctrl_d.rf_wr_sel = 2'd1;
            end
            OP_I, OP_IW: begin
                ctrl_d.rf_wr_en  = 1'b1;
                ctrl_d.alu_b_sel = 1'b1;
                ctrl_d.alu_ctrl  = alu_op(f3, (f3 == 3'b101) && f7[5]);
                ctrl_d.rf_wr_sel = 2'd1;
            end
            OP_LD: begin
                ctrl_d.rf_wr_en  = 1'b1;
                ctrl_d.alu_b_sel = 1'b1;
                ctrl_d.rf_wr_sel = 2'd2;
                ctrl_d.dm_rd     = f3 + 3'd1;
            end
            OP_ST: begin
                ctrl_d.alu_b_sel = 1'b1;
                ctrl_d.dm_wr     = f3 + 3'd1;
            end
            OP_BR: begin
                ctrl_d.alu_ctrl = ALU_SUB;
                case (f3)
                    3'b000:  ctrl_d.br_type = 3'd1;
                    3'b001:  ctrl_d.br_type = 3'd2;
                    3'b100:  ctrl_d.br_type = 3'd3;
                    3'b101:  ctrl_d.br_type = 3'd4;
                    3'b110:  ctrl_d.br_type = 3'd5;
                    3'b111:  ctrl_d.br_type = 3'd6;
                    default: ctrl_d.br_type = 3'd0;
                endcase
            end
            OP_JAL, OP_JALR: begin
                ctrl_d.rf_wr_en  = 1'b1;
                ctrl_d.do_jump   = 1'b1;
                ctrl_d.alu_a_sel = (opc == OP_JAL);
                ctrl_d.alu_b_sel = 1'b1;
                ctrl_d.rf_wr_sel = 2'd3;
            end
            OP_LUI: begin
                ctrl_d.rf_wr_en  = 1'b1;
                ctrl_d.alu_b_sel = 1'b1;
                ctrl_d.alu_ctrl  = ALU_PASSB;
                ctrl_d.rf_wr_sel = 2'd1;
            end
            OP_AUIPC: begin
                ctrl_d.rf_wr_en  = 1'b1;
                ctrl_d.alu_a_sel = 1'b1;
                ctrl_d.alu_b_sel = 1'b1;
                ctrl_d.rf_wr_sel = 2'd1;
            end
            default: ctrl_d = '0;
        endcase
    end

    logic [NUM_OPS-1:0][4:0]      rs_pk;
    logic [NUM_OPS-1:0][XLEN-1:0] rf_pk, op_pk;
    assign rs_pk = {rs2, rs1};
    assign rf_pk = {bus.data_reg_read_2, bus.data_reg_read_1};

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
        pipeline_id_stage_hs_fwd #(.XLEN(XLEN)) u_fwd (
            .r          (rs_pk[g]),
            .rf_data    (rf_pk[g]),
            .ex_rd      (bus.ex_rd),
            .mem_rd     (bus.mem_rd),
            .wb_rd      (bus.wb_rd),
            .ex_wr_en   (bus.ex_wr_en),
            .mem_wr_en  (bus.mem_wr_en),
            .wb_wr_en   (bus.wb_wr_en),
            .ex_is_load (bus.ex_is_load),
            .ex_data    (bus.ex_fwd_data),
            .mem_data   (bus.mem_fwd_data),
            .wb_data    (bus.wb_fwd_data),
            .op         (op_pk[g])
        );
    end

    ctrl_t                        ctrl_q;
    logic [NUM_OPS-1:0][XLEN-1:0] op_q;
    logic [4:0]                   rs1_q, rs2_q, rd_q;
    logic [6:0]                   opc_q, f7_q;
    logic [2:0]                   f3_q;
    logic [XLEN-1:0]              imm_q, pc_q;
    logic [CNT_W-1:0]             cnt_q;

    // Bubbles clear only the control word; data fields keep their last captured value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            op_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            opc_q       <= '0;
            f7_q        <= '0;
            f3_q        <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            cnt_q       <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
        end else if (advance) begin
            if (hazard) begin
                out_valid_q <= 1'b0;
                ctrl_q      <= '0;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end else if (bus.in_valid) begin
                out_valid_q <= 1'b1;
                ctrl_q      <= ctrl_d;
                op_q        <= op_pk;
                rs1_q       <= rs1;
                rs2_q       <= rs2;
                rd_q        <= inst[11:7];
                opc_q       <= opc;
                f7_q        <= f7;
                f3_q        <= f3;
                imm_q       <= imm64[XLEN-1:0];
                pc_q        <= bus.pc_ID;
            end else begin
                out_valid_q <= 1'b0;
                ctrl_q      <= '0;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.reg_data1_ID = op_q[0];
    assign bus.reg_data2_ID = op_q[1];
    assign bus.rs1_ID       = rs1_q;
    assign bus.rs2_ID       = rs2_q;
    assign bus.rd_ID        = rd_q;
    assign bus.opcode_ID    = opc_q;
    assign bus.funct3_ID    = f3_q;
    assign bus.funct7_ID    = f7_q;
    assign bus.imm_ID       = imm_q;
    assign bus.pc_out       = pc_q;
    assign bus.rf_wr_en     = ctrl_q.rf_wr_en;
    assign bus.do_jump      = ctrl_q.do_jump;
    assign bus.alu_a_sel    = ctrl_q.alu_a_sel;
    assign bus.alu_b_sel    = ctrl_q.alu_b_sel;
    assign bus.alu_ctrl     = ctrl_q.alu_ctrl;
    assign bus.BrType       = ctrl_q.br_type;
    assign bus.rf_wr_sel    = ctrl_q.rf_wr_sel;
    assign bus.dm_rd_ctrl   = ctrl_q.dm_rd;
    assign bus.dm_wr_ctrl   = ctrl_q.dm_wr;
    assign bus.stall_cnt    = cnt_q;
endmodule

// File: tb/tb_pipeline_id_stage_hs.sv
// Directed bench for pipeline_id_stage_hs: a 64-bit instance for the main flow and a
// 32-bit instance with a 2-bit counter for immediate truncation and counter saturation.
module tb_pipeline_id_stage_hs;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipeline_id_stage_hs_if #(.XLEN(64), .CNT_W(16)) u_if ();
    pipeline_id_stage_hs_if #(.XLEN(32), .CNT_W(2))  b_if ();

    pipeline_id_stage_hs #(.XLEN(64), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(u_if.slave));
    pipeline_id_stage_hs #(.XLEN(32), .CNT_W(2))  dut32 (.clk(clk), .reset(reset), .bus(b_if.slave));

    localparam logic [31:0] ADD3  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] SUB4  = 32'h40118233; // sub  x4,x3,x1
    localparam logic [31:0] ADD6  = 32'h00228333; // add  x6,x5,x2
    localparam logic [31:0] LUI5  = 32'h123452B7; // lui  x5,0x12345
    localparam logic [31:0] SD    = 32'h0020B423; // sd   x2,8(x1)
    localparam logic [31:0] ADD8  = 32'h00738433; // add  x8,x7,x7
    localparam logic [31:0] ADD9  = 32'h002004B3; // add  x9,x0,x2
    localparam logic [31:0] ADDIM = 32'hFFF00093; // addi x1,x0,-1

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pipe();
        u_if.ex_rd = 0; u_if.mem_rd = 0; u_if.wb_rd = 0;
        u_if.ex_wr_en = 0; u_if.mem_wr_en = 0; u_if.wb_wr_en = 0; u_if.ex_is_load = 0;
        u_if.ex_fwd_data = 0; u_if.mem_fwd_data = 0; u_if.wb_fwd_data = 0;
    endtask

    initial begin
        reset = 1'b0;
        u_if.in_valid = 0; u_if.instruction_ID = 0; u_if.pc_ID = 0; u_if.flush = 0;
        u_if.data_reg_read_1 = 0; u_if.data_reg_read_2 = 0; u_if.out_ready = 1;
        clr_pipe();
        b_if.in_valid = 0; b_if.instruction_ID = 0; b_if.pc_ID = 0; b_if.flush = 0;
        b_if.data_reg_read_1 = 0; b_if.data_reg_read_2 = 0; b_if.out_ready = 1;
        b_if.ex_rd = 0; b_if.mem_rd = 0; b_if.wb_rd = 0;
        b_if.ex_wr_en = 0; b_if.mem_wr_en = 0; b_if.wb_wr_en = 0; b_if.ex_is_load = 0;
        b_if.ex_fwd_data = 0; b_if.mem_fwd_data = 0; b_if.wb_fwd_data = 0;
        step(); step();

        chk("rst_valid", u_if.out_valid, 0);
        chk("rst_cnt", u_if.stall_cnt, 0);
        chk("rst_wr_en", u_if.rf_wr_en, 0);
        chk("rst_pc", u_if.pc_out, 0);
        chk("rst_imm", u_if.imm_ID, 0);
        reset = 1'b1;

        // add x3,x1,x2 then sub x4,x3,x1 with x3 forwarded from MEM
        u_if.in_valid = 1; u_if.instruction_ID = ADD3; u_if.pc_ID = 64'h1000;
        u_if.data_reg_read_1 = 64'h11; u_if.data_reg_read_2 = 64'h22;
        #1;
        chk("addr1", u_if.addr_reg_read_1, 1);
        chk("addr2", u_if.addr_reg_read_2, 2);
        chk("rdy_add", u_if.in_ready, 1);
        step();
        chk("add_valid", u_if.out_valid, 1);
        chk("add_op1", u_if.reg_data1_ID, 64'h11);
        chk("add_op2", u_if.reg_data2_ID, 64'h22);
        chk("add_rd", u_if.rd_ID, 3);
        chk("add_pc", u_if.pc_out, 64'h1000);
        chk("add_wr_en", u_if.rf_wr_en, 1);
        u_if.instruction_ID = SUB4; u_if.pc_ID = 64'h1004;
        u_if.data_reg_read_1 = 64'h99; u_if.data_reg_read_2 = 64'h11;
        u_if.mem_rd = 3; u_if.mem_wr_en = 1; u_if.mem_fwd_data = 64'h55;
        #1;
        chk("rdy_sub", u_if.in_ready, 1);
        step();
        chk("sub_valid", u_if.out_valid, 1);
        chk("sub_op1_fwd", u_if.reg_data1_ID, 64'h55);
        chk("sub_op2", u_if.reg_data2_ID, 64'h11);
        chk("sub_f7", u_if.funct7_ID, 7'h20);
        chk("sub_rd", u_if.rd_ID, 4);

        // load-use: ld x5 in EX, add x6,x5,x2 in ID -> exactly one bubble
        clr_pipe();
        u_if.ex_is_load = 1; u_if.ex_wr_en = 1; u_if.ex_rd = 5;
        u_if.instruction_ID = ADD6; u_if.pc_ID = 64'h1008;
        u_if.data_reg_read_1 = 64'h0; u_if.data_reg_read_2 = 64'h22;
        #1;
        chk("rdy_hazard", u_if.in_ready, 0);
        step();
        chk("bub_valid", u_if.out_valid, 0);
        chk("bub_wr_en", u_if.rf_wr_en, 0);
        chk("bub_cnt", u_if.stall_cnt, 1);
        clr_pipe();
        u_if.mem_rd = 5; u_if.mem_wr_en = 1; u_if.mem_fwd_data = 64'hAB;
        #1;
        chk("rdy_after_bub", u_if.in_ready, 1);
        step();
        chk("lu_valid", u_if.out_valid, 1);
        chk("lu_op1", u_if.reg_data1_ID, 64'hAB);
        chk("lu_rd", u_if.rd_ID, 6);
        chk("lu_cnt", u_if.stall_cnt, 1);

        // lui x5 with a load to x5 in EX: no rs use, no hazard
        clr_pipe();
        u_if.ex_is_load = 1; u_if.ex_wr_en = 1; u_if.ex_rd = 5;
        u_if.instruction_ID = LUI5; u_if.pc_ID = 64'h1010;
        #1;
        chk("rdy_lui", u_if.in_ready, 1);
        step();
        chk("lui_valid", u_if.out_valid, 1);
        chk("lui_imm", u_if.imm_ID, 64'h12345000);
        chk("lui_cnt", u_if.stall_cnt, 1);

        // backpressure for 3 cycles, then release latches the store
        clr_pipe();
        u_if.out_ready = 0; u_if.instruction_ID = SD; u_if.pc_ID = 64'h2000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rdy", u_if.in_ready, 0);
            step();
            chk("bp_valid", u_if.out_valid, 1);
            chk("bp_pc", u_if.pc_out, 64'h1010);
            chk("bp_imm", u_if.imm_ID, 64'h12345000);
        end
        u_if.out_ready = 1;
        #1;
        chk("rel_rdy", u_if.in_ready, 1);
        step();
        chk("sd_pc", u_if.pc_out, 64'h2000);
        chk("sd_imm", u_if.imm_ID, 64'h8);
        chk("sd_dm_wr_nz", u_if.dm_wr_ctrl != 0, 1);
        chk("sd_wr_en", u_if.rf_wr_en, 0);

        // flush while stalled downstream
        u_if.out_ready = 0; u_if.flush = 1; u_if.instruction_ID = ADD3;
        #1;
        chk("flush_rdy", u_if.in_ready, 1);
        step();
        chk("flush_valid", u_if.out_valid, 0);
        chk("flush_dm_wr", u_if.dm_wr_ctrl, 0);
        u_if.flush = 0; u_if.out_ready = 1;

        // forwarding priority on x7: EX, then MEM, then WB
        u_if.instruction_ID = ADD8; u_if.pc_ID = 64'h3000;
        u_if.data_reg_read_1 = 64'h77; u_if.data_reg_read_2 = 64'h77;
        u_if.ex_rd = 7; u_if.ex_wr_en = 1; u_if.ex_fwd_data = 64'hE1;
        u_if.mem_rd = 7; u_if.mem_wr_en = 1; u_if.mem_fwd_data = 64'hE2;
        u_if.wb_rd = 7; u_if.wb_wr_en = 1; u_if.wb_fwd_data = 64'hE3;
        step();
        chk("pri_ex1", u_if.reg_data1_ID, 64'hE1);
        chk("pri_ex2", u_if.reg_data2_ID, 64'hE1);
        u_if.ex_wr_en = 0;
        step();
        chk("pri_mem", u_if.reg_data1_ID, 64'hE2);
        u_if.mem_wr_en = 0;
        step();
        chk("pri_wb", u_if.reg_data2_ID, 64'hE3);
        u_if.wb_wr_en = 0;
        step();
        chk("pri_rf", u_if.reg_data1_ID, 64'h77);

        // rs1 = x0 with matching writers targeting x0
        u_if.instruction_ID = ADD9; u_if.pc_ID = 64'h3010;
        u_if.data_reg_read_1 = 64'h1234; u_if.data_reg_read_2 = 64'h22;
        u_if.ex_rd = 0; u_if.ex_wr_en = 1; u_if.ex_fwd_data = 64'hBEEF;
        u_if.wb_rd = 0; u_if.wb_wr_en = 1; u_if.wb_fwd_data = 64'hDEAD;
        step();
        chk("x0_op1", u_if.reg_data1_ID, 0);
        chk("x0_op2", u_if.reg_data2_ID, 64'h22);
        chk("x0_pc", u_if.pc_out, 64'h3010);

        // reset in the middle of a stall
        clr_pipe();
        u_if.ex_is_load = 1; u_if.ex_wr_en = 1; u_if.ex_rd = 5;
        u_if.instruction_ID = ADD6;
        step();
        chk("st2_cnt", u_if.stall_cnt, 2);
        chk("st2_valid", u_if.out_valid, 0);
        reset = 1'b0;
        step();
        chk("mrst_valid", u_if.out_valid, 0);
        chk("mrst_cnt", u_if.stall_cnt, 0);
        chk("mrst_pc", u_if.pc_out, 0);
        chk("mrst_rd", u_if.rd_ID, 0);
        chk("mrst_op1", u_if.reg_data1_ID, 0);
        reset = 1'b1;
        clr_pipe();
        u_if.in_valid = 0;
        step();
        chk("post_valid", u_if.out_valid, 0);
        chk("post_cnt", u_if.stall_cnt, 0);

        // 32-bit build: 2-bit counter saturates at 3, addi -1 truncates to 32 bits
        chk("b_cnt0", b_if.stall_cnt, 0);
        b_if.in_valid = 1; b_if.instruction_ID = ADD6; b_if.pc_ID = 32'h80;
        b_if.ex_is_load = 1; b_if.ex_wr_en = 1; b_if.ex_rd = 5;
        step(); step();
        chk("b_cnt2", b_if.stall_cnt, 2);
        step(); step(); step();
        chk("b_cnt_sat", b_if.stall_cnt, 3);
        chk("b_bub_valid", b_if.out_valid, 0);
        b_if.ex_is_load = 0; b_if.ex_wr_en = 0; b_if.ex_rd = 0;
        b_if.instruction_ID = ADDIM;
        step();
        chk("b_valid", b_if.out_valid, 1);
        chk("b_imm", b_if.imm_ID, 64'hFFFFFFFF);
        chk("b_rd", b_if.rd_ID, 1);
        chk("b_cnt_hold", b_if.stall_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
